// File: rtl/cassette_pkg.sv
// Shared state encodings and defaults for the cassette transport.
package cassette_pkg;

  localparam int POS_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_EMPTY   = 3'd0,
    ST_STOPPED = 3'd1,
    ST_PLAYING = 3'd2,
    ST_FFWD    = 3'd3,
    ST_REWIND  = 3'd4
  } cass_state_e;

  function automatic logic is_motion(cass_state_e s);
    return (s == ST_PLAYING) ||
           (s == ST_FFWD) ||
           (s == ST_REWIND);
  endfunction

endpackage

// File: rtl/cass_prescaler.sv
// ce-gated divider; step fires on the ce cycle that hits the selected terminal count.
module cass_prescaler #(
  parameter int DIV_W = 13
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_tick,
  input  logic             clr,
  input  logic [DIV_W-1:0] tc,
  output logic             step
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  assign step = ce_tick && (div_q == tc);

  always_comb begin
    div_d = div_q;
    if (clr || step) begin
      div_d = '0;
    end else if (ce_tick) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/cassette_transport_ctrl.sv
// Virtual cassette transport: command FSM, tape position and overlay enable hold.
module cassette_transport_ctrl
  import cassette_pkg::*;
#(
  parameter int POS_W     = POS_W_DEF,
  parameter int PLAY_DIV  = 6667,
  parameter int WIND_DIV  = 417,
  parameter int WIND_STEP = 4,
  parameter int HOLD_TKS  = 16
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_tick,
  input  logic             tape_load,
  input  logic [POS_W-1:0] tape_len,
  input  logic             cmd_play,
  input  logic             cmd_stop,
  input  logic             cmd_ff,
  input  logic             cmd_rew,
  input  logic             cmd_eject,
  input  logic             loop_en,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] max,
  output logic [2:0]       state,
  output logic             motor,
  output logic             at_end,
  output logic             ena
);

  localparam int DIV_MAX = (PLAY_DIV > WIND_DIV) ? PLAY_DIV : WIND_DIV;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam int HOLD_W  = $clog2(HOLD_TKS + 1);

  localparam logic [DIV_W-1:0]  PLAY_TC   = DIV_W'(PLAY_DIV - 1);
  localparam logic [DIV_W-1:0]  WIND_TC   = DIV_W'(WIND_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TKS);
  localparam logic [POS_W:0]    STEP_X    = (POS_W + 1)'(WIND_STEP);
  localparam logic [POS_W:0]    ONE_X     = (POS_W + 1)'(1);

  cass_state_e       state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [POS_W-1:0]  max_q, max_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              motor_q, motor_d;
  logic              at_end_q, at_end_d;
  logic              ena_q, ena_d;

  logic             step;
  logic             clr;
  logic [DIV_W-1:0] tc;
  logic             hit;
  logic             at_max;
  logic             at_zero;
  logic [POS_W:0]   pos_x;
  logic [POS_W:0]   max_x;
  logic [POS_W:0]   inc_x;
  logic [POS_W:0]   fwd_x;

  assign tc  = (state_q == ST_FFWD || state_q == ST_REWIND) ?
               WIND_TC : PLAY_TC;
  assign clr = (state_d != state_q);

  cass_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_tick (ce_tick),
    .clr     (clr),
    .tc      (tc),
    .step    (step)
  );

  assign pos_x   = {1'b0, pos_q};
  assign max_x   = {1'b0, max_q};
  assign inc_x   = pos_x + ONE_X;
  assign fwd_x   = pos_x + STEP_X;
  assign at_max  = (pos_q == max_q);
  assign at_zero = (pos_q == '0);

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    max_d    = max_q;
    at_end_d = 1'b0;
    hit      = 1'b0;
    if (state_q == ST_EMPTY) begin
      if (!cmd_eject && tape_load && tape_len != '0) begin
        max_d   = tape_len;
        pos_d   = '0;
        state_d = ST_STOPPED;
      end
    end else begin
      if (cmd_eject) begin
        hit     = 1'b1;
        state_d = ST_EMPTY;
        pos_d   = '0;
        max_d   = '0;
      end else if (tape_load) begin
        // A zero-length tape is treated the same as no tape.
        hit     = 1'b1;
        pos_d   = '0;
        max_d   = tape_len;
        state_d = (tape_len == '0) ? ST_EMPTY : ST_STOPPED;
      end else if (cmd_stop) begin
        hit     = (state_q != ST_STOPPED);
        state_d = ST_STOPPED;
      end else if (cmd_rew) begin
        if (state_q != ST_REWIND && !at_zero) begin
          hit     = 1'b1;
          state_d = ST_REWIND;
        end
      end else if (cmd_ff) begin
        if (state_q != ST_FFWD && !at_max) begin
          hit     = 1'b1;
          state_d = ST_FFWD;
        end
      end else if (cmd_play) begin
        if (state_q != ST_PLAYING && (!at_max || loop_en)) begin
          hit     = 1'b1;
          state_d = ST_PLAYING;
          if (at_max) pos_d = '0;
        end
      end
      if (!hit && step) begin
        unique case (state_q)
          ST_PLAYING: begin
            if (at_max) begin
              if (loop_en) pos_d = '0;
              else state_d = ST_STOPPED;
            end else begin
              pos_d    = inc_x[POS_W-1:0];
              at_end_d = (inc_x == max_x);
            end
          end
          ST_FFWD: begin
            if (fwd_x >= max_x) begin
              pos_d    = max_q;
              state_d  = ST_STOPPED;
              at_end_d = 1'b1;
            end else begin
              pos_d = fwd_x[POS_W-1:0];
            end
          end
          ST_REWIND: begin
            if (pos_x <= STEP_X) begin
              pos_d   = '0;
              state_d = ST_STOPPED;
            end else begin
              pos_d = pos_q - STEP_X[POS_W-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Hold only counts in STOPPED, paced by the PLAY-rate prescaler.
  always_comb begin
    hold_d = hold_q;
    if (state_d != ST_STOPPED) begin
      hold_d = '0;
    end else if (is_motion(state_q)) begin
      hold_d = HOLD_INIT;
    end else if (step && hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
    motor_d = is_motion(state_d);
    ena_d   = motor_d || (hold_d != '0);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      pos_q    <= '0;
      max_q    <= '0;
      hold_q   <= '0;
      motor_q  <= 1'b0;
      at_end_q <= 1'b0;
      ena_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      max_q    <= max_d;
      hold_q   <= hold_d;
      motor_q  <= motor_d;
      at_end_q <= at_end_d;
      ena_q    <= ena_d;
    end
  end

  assign pos    = pos_q;
  assign max    = max_q;
  assign state  = state_q;
  assign motor  = motor_q;
  assign at_end = at_end_q;
  assign ena    = ena_q;

endmodule

// File: tb/tb_cassette_transport_ctrl.sv
// Directed bench for cassette_transport_ctrl with short dividers.
module tb_cassette_transport_ctrl;

  localparam int PW = 24;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ce_tick = 1'b1;
  logic          tape_load = 1'b0;
  logic [PW-1:0] tape_len = '0;
  logic          cmd_play = 1'b0;
  logic          cmd_stop = 1'b0;
  logic          cmd_ff = 1'b0;
  logic          cmd_rew = 1'b0;
  logic          cmd_eject = 1'b0;
  logic          loop_en = 1'b0;
  logic [PW-1:0] pos;
  logic [PW-1:0] max;
  logic [2:0]    state;
  logic          motor;
  logic          at_end;
  logic          ena;

  int checks = 0;
  int errors = 0;

  cassette_transport_ctrl #(
    .POS_W     (PW),
    .PLAY_DIV  (4),
    .WIND_DIV  (2),
    .WIND_STEP (4),
    .HOLD_TKS  (2)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce_tick   (ce_tick),
    .tape_load (tape_load),
    .tape_len  (tape_len),
    .cmd_play  (cmd_play),
    .cmd_stop  (cmd_stop),
    .cmd_ff    (cmd_ff),
    .cmd_rew   (cmd_rew),
    .cmd_eject (cmd_eject),
    .loop_en   (loop_en),
    .pos       (pos),
    .max       (max),
    .state     (state),
    .motor     (motor),
    .at_end    (at_end),
    .ena       (ena)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic load(input int len);
    tape_load = 1'b1;
    tape_len  = PW'(len);
    tick();
    tape_load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++;
    if (pos !== '0 || max !== '0) begin errors++; $display("FAIL rst_pos got %0d/%0d exp 0/0", pos, max); end
    checks++;
    if ({motor, at_end, ena} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {motor, at_end, ena}); end
  endtask

  task automatic test_play_stop_end();
    load(10);
    checks++;
    if (state !== 3'd1 || max !== 24'd10) begin errors++; $display("FAIL load got st %0d max %0d exp 1 10", state, max); end
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    checks++;
    if (state !== 3'd2 || motor !== 1'b1 || ena !== 1'b1) begin errors++; $display("FAIL play_start got st %0d m %b e %b exp 2 1 1", state, motor, ena); end
    for (int k = 1; k <= 10; k++) begin
      repeat (4) tick();
      checks++;
      if (pos !== PW'(k)) begin errors++; $display("FAIL play_pos got %0d exp %0d", pos, k); end
      checks++;
      if (at_end !== 1'(k == 10)) begin errors++; $display("FAIL play_at_end at %0d got %b exp %b", k, at_end, k == 10); end
    end
    repeat (4) tick();
    checks++;
    if (state !== 3'd1 || pos !== 24'd10 || motor !== 1'b0 || ena !== 1'b1) begin
      errors++; $display("FAIL play_end got st %0d pos %0d m %b e %b exp 1 10 0 1", state, pos, motor, ena);
    end
  endtask

  task automatic test_loop();
    int n_end;
    load(10);
    loop_en  = 1'b1;
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    repeat (40) tick();
    checks++;
    if (pos !== 24'd10 || at_end !== 1'b1) begin errors++; $display("FAIL loop_end got pos %0d ae %b exp 10 1", pos, at_end); end
    repeat (4) tick();
    checks++;
    if (pos !== '0 || state !== 3'd2) begin errors++; $display("FAIL loop_wrap got pos %0d st %0d exp 0 2", pos, state); end
    n_end = 0;
    for (int i = 0; i < 44; i++) begin
      tick();
      if (at_end === 1'b1) n_end++;
    end
    checks++;
    if (n_end != 1) begin errors++; $display("FAIL loop_pulses got %0d exp 1", n_end); end
    checks++;
    if (pos !== '0 || state !== 3'd2) begin errors++; $display("FAIL loop_wrap2 got pos %0d st %0d exp 0 2", pos, state); end
  endtask

  task automatic test_ff_rew();
    loop_en = 1'b0;
    repeat (36) tick();
    checks++;
    if (pos !== 24'd9) begin errors++; $display("FAIL pre_ff got %0d exp 9", pos); end
    cmd_ff = 1'b1;
    tick();
    cmd_ff = 1'b0;
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL ff_state got %0d exp 3", state); end
    repeat (2) tick();
    checks++;
    if (pos !== 24'd10 || state !== 3'd1 || at_end !== 1'b1) begin
      errors++; $display("FAIL ff_sat got pos %0d st %0d ae %b exp 10 1 1", pos, state, at_end);
    end
    cmd_rew = 1'b1;
    tick();
    cmd_rew = 1'b0;
    checks++;
    if (state !== 3'd4) begin errors++; $display("FAIL rew_state got %0d exp 4", state); end
    repeat (2) tick();
    checks++;
    if (pos !== 24'd6) begin errors++; $display("FAIL rew_6 got %0d exp 6", pos); end
    repeat (2) tick();
    checks++;
    if (pos !== 24'd2 || state !== 3'd4) begin errors++; $display("FAIL rew_2 got pos %0d st %0d exp 2 4", pos, state); end
    repeat (2) tick();
    checks++;
    if (pos !== '0 || state !== 3'd1 || at_end !== 1'b0) begin
      errors++; $display("FAIL rew_0 got pos %0d st %0d ae %b exp 0 1 0", pos, state, at_end);
    end
  endtask

  task automatic test_priority();
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    cmd_stop = 1'b1;
    cmd_play = 1'b1;
    tick();
    cmd_stop = 1'b0;
    cmd_play = 1'b0;
    checks++;
    if (state !== 3'd1 || ena !== 1'b1) begin errors++; $display("FAIL stop_play got st %0d e %b exp 1 1", state, ena); end
    cmd_eject = 1'b1;
    cmd_play  = 1'b1;
    tick();
    cmd_eject = 1'b0;
    cmd_play  = 1'b0;
    checks++;
    if (state !== 3'd0 || pos !== '0 || max !== '0 || ena !== 1'b0 || motor !== 1'b0) begin
      errors++; $display("FAIL eject got st %0d pos %0d max %0d e %b exp 0 0 0 0", state, pos, max, ena);
    end
  endtask

  task automatic test_empty();
    load(0);
    checks++;
    if (state !== 3'd0 || max !== '0) begin errors++; $display("FAIL load0 got st %0d max %0d exp 0 0", state, max); end
    cmd_play = 1'b1;
    repeat (3) tick();
    cmd_play = 1'b0;
    checks++;
    if (state !== 3'd0 || motor !== 1'b0 || pos !== '0) begin errors++; $display("FAIL empty_play got st %0d m %b exp 0 0", state, motor); end
  endtask

  task automatic test_hold_and_reset();
    load(10);
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    repeat (8) tick();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    checks++;
    if (state !== 3'd1 || pos !== 24'd2 || ena !== 1'b1) begin
      errors++; $display("FAIL stop got st %0d pos %0d e %b exp 1 2 1", state, pos, ena);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (ena !== 1'b1) begin errors++; $display("FAIL hold_on at %0d got %b exp 1", i, ena); end
    end
    tick();
    checks++;
    if (ena !== 1'b0) begin errors++; $display("FAIL hold_off got %b exp 0", ena); end
    cmd_ff = 1'b1;
    tick();
    cmd_ff = 1'b0;
    tick();
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL pre_rst got st %0d exp 3", state); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (state !== 3'd0 || pos !== '0 || max !== '0 || {motor, at_end, ena} !== 3'b000) begin
      errors++; $display("FAIL mid_rst got st %0d pos %0d max %0d f %b exp 0 0 0 000", state, pos, max, {motor, at_end, ena});
    end
    cmd_play = 1'b1;
    tick();
    cmd_play = 1'b0;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL post_rst got st %0d exp 0", state); end
  endtask

  initial begin
    test_reset();
    test_play_stop_end();
    test_loop();
    test_ff_rew();
    test_priority();
    test_empty();
    test_hold_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
